// File: rtl/pulse_tx_pkg.sv
// rtl/pulse_tx_pkg.sv - shared types and helpers for the pulse request transmitter
package pulse_tx_pkg;

  // Handshake phases of the transmit side
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } tx_state_t;

  // Width of a counter that must reach min_hi-1; never narrower than one bit
  function automatic int hi_cnt_width(input int min_hi);
    return (min_hi > 1) ? $clog2(min_hi) : 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with asynchronous active-high reset
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pulse_req_tx.sv
// rtl/pulse_req_tx.sv - event pulses to 4-phase req/ack handshake, source side of a crossing
module pulse_req_tx
  import pulse_tx_pkg::*;
#(
  parameter int PEND_W = 3,
  parameter int MIN_HI = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              ack_in,
  input  logic              clr_ovf,
  output logic              req_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int                HI_W     = hi_cnt_width(MIN_HI);
  localparam logic [HI_W-1:0]   HI_LAST  = HI_W'(MIN_HI - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  tx_state_t       state;
  logic [HI_W-1:0] hi_cnt;
  logic            ack_s;
  logic            launch;
  logic            drop;

  // The acknowledge comes from another clock domain and is only used synchronized
  sync2 #(.W(1)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_in),
    .q   (ack_s)
  );

  // A new handshake starts from IDLE whenever something is queued or arriving now
  always_comb begin
    launch = (state == IDLE) && ((pend_cnt != '0) || pulse_in);
    drop   = pulse_in && !launch && (pend_cnt == PEND_MAX);
  end

  assign busy = (state != IDLE) || (pend_cnt != '0);

  // Pending-event queue depth; an arrival and a launch in the same cycle cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt <= '0;
    end else if (!drop) begin
      pend_cnt <= pend_cnt + PEND_W'(pulse_in) - PEND_W'(launch);
    end
  end

  // Sticky drop flag; a fresh drop wins over a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Handshake FSM; req_out is set on entry to REQ_HI and cleared on exit so it is a clean flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_out <= 1'b0;
      hi_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state   <= REQ_HI;
            req_out <= 1'b1;
            hi_cnt  <= '0;
          end
        end
        REQ_HI: begin
          if (hi_cnt != HI_LAST) begin
            hi_cnt <= hi_cnt + 1'b1;
          end
          if (ack_s && (hi_cnt == HI_LAST)) begin
            state   <= REQ_LO;
            req_out <= 1'b0;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          req_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_req_tx.sv
// tb/tb_pulse_req_tx.sv - directed self-checking bench for pulse_req_tx
module tb_pulse_req_tx;

  logic       clk;
  logic       rst;

  logic       pulse_in, ack_in, clr_ovf;
  logic       req_out, busy, overflow;
  logic [2:0] pend_cnt;

  logic       pulse2, ack2, clr2, ack2_drv, inst_mode;
  logic       req2, busy2, ovf2;
  logic [1:0] pend2;

  logic       resp_ack, ack_force_en, ack_force;

  int checks = 0;
  int errors = 0;
  int rises = 0, short_cnt = 0, hi_len = 0;
  int rises2 = 0, short2 = 0, hi_len2 = 0, last_len2 = 0;
  int peak = 0;
  int base;

  pulse_req_tx #(.PEND_W(3), .MIN_HI(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .ack_in   (ack_in),
    .clr_ovf  (clr_ovf),
    .req_out  (req_out),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .overflow (overflow)
  );

  pulse_req_tx #(.PEND_W(2), .MIN_HI(4)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse2),
    .ack_in   (ack2),
    .clr_ovf  (clr2),
    .req_out  (req2),
    .busy     (busy2),
    .pend_cnt (pend2),
    .overflow (ovf2)
  );

  assign ack_in = ack_force_en ? ack_force : resp_ack;
  assign ack2   = inst_mode ? req2 : ack2_drv;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder: echoes req_out after 0-5 cycles with an offset away from the clock edge
  initial begin
    resp_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_ack != req_out) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #3;
        resp_ack = req_out;
      end
    end
  end

  // Request pulse monitors: count rises and pulses shorter than the minimum high time
  always @(negedge clk) begin
    if (rst) begin
      hi_len  = 0;
      hi_len2 = 0;
    end else begin
      if (req_out) begin
        if (hi_len == 0) rises++;
        hi_len++;
      end else begin
        if (hi_len != 0 && hi_len < 2) short_cnt++;
        hi_len = 0;
      end
      if (req2) begin
        if (hi_len2 == 0) rises2++;
        hi_len2++;
      end else begin
        if (hi_len2 != 0 && hi_len2 < 4) short2++;
        if (hi_len2 != 0) last_len2 = hi_len2;
        hi_len2 = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      step();
      n++;
      if (int'(pend_cnt) > peak) peak = int'(pend_cnt);
    end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_idle2(input string tag);
    int n = 0;
    while (busy2 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, busy2, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pulse_in = 0; clr_ovf = 0; ack_force_en = 0; ack_force = 0;
    pulse2 = 0; clr2 = 0; ack2_drv = 0; inst_mode = 0;
    step();
    chk("rst_req", req_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_ovf", overflow, 0);
    step();
    rst = 1'b0;
    step();

    // 1: single event, one-cycle latency
    base = rises;
    pulse_in = 1;
    chk("t1_req_pre", req_out, 0);
    step();
    pulse_in = 0;
    chk("t1_req_n1", req_out, 1);
    chk("t1_pend", pend_cnt, 0);
    chk("t1_busy", busy, 1);
    wait_idle("t1");
    chk("t1_rises", rises - base, 1);
    chk("t1_short", short_cnt, 0);
    chk("t1_ack_low", ack_in, 0);

    // 2: burst of five back-to-back events
    base = rises;
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      pulse_in = 1;
      step();
      if (int'(pend_cnt) > peak) peak = int'(pend_cnt);
    end
    pulse_in = 0;
    wait_idle("t2");
    chk("t2_rises", rises - base, 5);
    chk("t2_peak", peak, 4);
    chk("t2_ovf", overflow, 0);
    chk("t2_short", short_cnt, 0);

    // 3: overflow on the narrow instance with ack held low
    for (int i = 0; i < 6; i++) begin
      pulse2 = 1;
      step();
    end
    pulse2 = 0;
    chk("t3_pend", pend2, 3);
    chk("t3_ovf", ovf2, 1);
    chk("t3_rises", rises2, 1);
    chk("t3_req", req2, 1);
    pulse2 = 1; clr2 = 1;
    step();
    pulse2 = 0;
    chk("t3_set_prio", ovf2, 1);
    chk("t3_pend_hold", pend2, 3);
    step();
    clr2 = 0;
    chk("t3_clr", ovf2, 0);
    inst_mode = 1;
    wait_idle2("t3");
    chk("t3_rises_all", rises2, 4);
    chk("t3_pend_end", pend2, 0);

    // 4: ack tied to req, every high pulse at least MIN_HI
    base = rises2;
    for (int i = 0; i < 3; i++) begin
      pulse2 = 1;
      step();
    end
    pulse2 = 0;
    wait_idle2("t4");
    chk("t4_rises", rises2 - base, 3);
    chk("t4_short", short2, 0);
    chk("t4_len", last_len2, 4);

    // 5: reset in REQ_HI with two events queued
    ack_force_en = 1; ack_force = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_in = 1;
      step();
    end
    pulse_in = 0;
    chk("t5_pend_pre", pend_cnt, 2);
    chk("t5_req_pre", req_out, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_req_async", req_out, 0);
    chk("t5_pend_async", pend_cnt, 0);
    step();
    rst = 1'b0;
    base = rises;
    repeat (10) step();
    chk("t5_pend", pend_cnt, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_busy", busy, 0);
    chk("t5_no_rise", rises - base, 0);

    // 6: stuck-high ack parks the FSM in REQ_LO
    ack_force = 1;
    base = rises;
    for (int i = 0; i < 2; i++) begin
      pulse_in = 1;
      step();
    end
    pulse_in = 0;
    repeat (20) step();
    chk("t6_rises_stuck", rises - base, 1);
    chk("t6_busy", busy, 1);
    chk("t6_req", req_out, 0);
    chk("t6_pend", pend_cnt, 1);
    ack_force_en = 0;
    wait_idle("t6");
    chk("t6_rises_all", rises - base, 2);
    chk("t6_pend_end", pend_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
